// File: rtl/digi_ota_decimator_if.sv
// Result handshake bundle for the OTA decimator: density code plus valid/ready.
interface digi_ota_decimator_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/digi_ota_decimator.sv
// Synchronizes the OTA comparator bit, counts ones over a 2^WINDOW_LOG2 window
// and hands out one saturated density code per window over valid/ready.
module digi_ota_decimator #(
  parameter int WINDOW_LOG2 = 8,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cmp_in,
  input  logic                  clr_ovr,
  output logic                  ovr,
  output logic                  busy,
  digi_ota_decimator_if.master  out_if
);

  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam int EXT_W = (CNT_W > OUT_W) ? CNT_W : OUT_W;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic [SET_W-1:0]       settle_cnt_r;
  logic [WINDOW_LOG2-1:0] sample_cnt_r;
  logic [CNT_W-1:0]       ones_cnt_r;
  logic [OUT_W-1:0]       out_data_r;
  logic                   out_valid_r;
  logic                   ovr_r;
  logic                   busy_r;
  logic                   settle_done_s;
  logic                   settle_step_s;
  logic                   accum_s;
  logic                   complete_s;
  logic [EXT_W-1:0]       final_ext_s;
  logic [OUT_W-1:0]       result_s;
  logic                   reg_free_s;

  // Saturate a window count into the OUT_W result code.
  function automatic logic [OUT_W-1:0] sat_code(input logic [EXT_W-1:0] cnt);
    if (cnt > SAT_MAX) begin
      sat_code = OUT_W'(SAT_MAX);
    end else begin
      sat_code = OUT_W'(cnt);
    end
  endfunction

  assign s_s           = sync_r[SYNC_STAGES-1];
  assign settle_done_s = (settle_cnt_r == SET_W'(SETTLE_CYC - 1));
  assign final_ext_s   = EXT_W'(ones_cnt_r) + EXT_W'(s_s);
  assign result_s      = sat_code(final_ext_s);
  assign reg_free_s    = !out_valid_r || out_if.out_ready;

  // Synchronizer chain for the asynchronous comparator bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], cmp_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; dropping en aborts from any active state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          next_state_s = ST_SETTLE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!en) begin
          next_state_s = ST_IDLE;
        end else if (settle_done_s) begin
          next_state_s = ST_ACCUM;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_ACCUM: begin
        if (!en) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ACCUM;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes for the current state.
  always_comb begin
    settle_step_s = 1'b0;
    accum_s       = 1'b0;
    complete_s    = 1'b0;
    case (state_r)
      ST_SETTLE: begin
        settle_step_s = en && !settle_done_s;
      end
      ST_ACCUM: begin
        accum_s    = en;
        complete_s = en && (sample_cnt_r == {WINDOW_LOG2{1'b1}});
      end
      default: begin
        settle_step_s = 1'b0;
        accum_s       = 1'b0;
        complete_s    = 1'b0;
      end
    endcase
  end

  // Settle and window counters; anything outside an active window reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= {SET_W{1'b0}};
      sample_cnt_r <= {WINDOW_LOG2{1'b0}};
      ones_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (settle_step_s) begin
        settle_cnt_r <= settle_cnt_r + SET_W'(1);
      end else begin
        settle_cnt_r <= {SET_W{1'b0}};
      end
      if (accum_s && !complete_s) begin
        sample_cnt_r <= sample_cnt_r + WINDOW_LOG2'(1);
        ones_cnt_r   <= ones_cnt_r + CNT_W'(s_s);
      end else begin
        sample_cnt_r <= {WINDOW_LOG2{1'b0}};
        ones_cnt_r   <= {CNT_W{1'b0}};
      end
    end
  end

  // Result register, handshake and sticky overrun; a same-cycle overrun beats clr_ovr.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      ovr_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      if (complete_s && reg_free_s) begin
        out_data_r  <= result_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_if.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (complete_s && !reg_free_s) begin
        ovr_r <= 1'b1;
      end else if (clr_ovr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  assign out_if.out_data  = out_data_r;
  assign out_if.out_valid = out_valid_r;
  assign ovr              = ovr_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_digi_ota_decimator.sv
// Scoreboard bench for digi_ota_decimator: expected window codes are queued as
// stimulus is set up and compared on every observed output transfer.
module tb_digi_ota_decimator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cmp_in = 1'b0;
  logic clr_ovr = 1'b0;
  logic ovr;
  logic busy;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic [7:0] sb_q[$];

  digi_ota_decimator_if #(.OUT_W(8)) dif ();

  digi_ota_decimator #(
    .WINDOW_LOG2(8), .OUT_W(8), .SYNC_STAGES(2), .SETTLE_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in), .clr_ovr(clr_ovr),
    .ovr(ovr), .busy(busy), .out_if(dif.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!dif.out_valid && n < 400) begin
      step(1);
      n++;
    end
  endtask

  task automatic run_windows(input int m, input int nwin, input logic [7:0] exp);
    mode = m;
    dif.out_ready = 1'b1;
    for (int i = 0; i < nwin; i++) sb_q.push_back(exp);
    en = 1'b1;
    step(261 + 256 * (nwin - 1) + 5);
    en = 1'b0;
    step(5);
    check_eq("run_ovr", 32'(ovr), 32'd0);
    check_eq("run_busy_off", 32'(busy), 32'd0);
    check_eq("run_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Comparator bitstream: 0 = zeros, 1 = ones, 2 = 50% toggle, 3 = 25% (1000).
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       cmp_in = 1'b1;
        2:       cmp_in = ph[0];
        3:       cmp_in = (ph[1:0] == 2'd0);
        default: cmp_in = 1'b0;
      endcase
      ph++;
    end
  end

  // Scoreboard: every transfer pops one expected code.
  always @(negedge clk) begin
    if (!rst && dif.out_valid && dif.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_xfer", 32'(dif.out_data), 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_data", 32'(dif.out_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    dif.out_ready = 1'b0;
    step(3);
    check_eq("rst_valid", 32'(dif.out_valid), 32'd0);
    check_eq("rst_data", 32'(dif.out_data), 32'd0);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(2);

    // Constant ones: saturated code, first-result latency and window period.
    mode = 1;
    dif.out_ready = 1'b1;
    repeat (3) sb_q.push_back(8'd255);
    en = 1'b1;
    step(1);
    check_eq("busy_on", 32'(busy), 32'd1);
    wait_valid(lat);
    check_eq("latency_first", 32'(lat + 1), 32'd261);
    step(1);
    check_eq("valid_pulse_end", 32'(dif.out_valid), 32'd0);
    step(255);
    check_eq("window_period", 32'(dif.out_valid), 32'd1);
    step(261);
    en = 1'b0;
    step(5);
    check_eq("t1_drained", 32'(sb_q.size()), 32'd0);

    run_windows(0, 2, 8'd0);
    run_windows(2, 2, 8'd128);
    run_windows(3, 2, 8'd64);

    // Backpressure: held result, overrun, clear, and load on a transfer-completion cycle.
    mode = 1;
    dif.out_ready = 1'b0;
    sb_q.push_back(8'd255);
    sb_q.push_back(8'd0);
    en = 1'b1;
    step(261);
    check_eq("bp_valid", 32'(dif.out_valid), 32'd1);
    check_eq("bp_data", 32'(dif.out_data), 32'd255);
    step(20);
    mode = 0;
    step(235);
    check_eq("bp_ovr_pre", 32'(ovr), 32'd0);
    step(1);
    check_eq("bp_ovr_set", 32'(ovr), 32'd1);
    check_eq("bp_data_held", 32'(dif.out_data), 32'd255);
    check_eq("bp_valid_held", 32'(dif.out_valid), 32'd1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    check_eq("bp_ovr_clr", 32'(ovr), 32'd0);
    step(254);
    dif.out_ready = 1'b1;
    step(1);
    check_eq("xc_valid", 32'(dif.out_valid), 32'd1);
    check_eq("xc_data", 32'(dif.out_data), 32'd0);
    check_eq("xc_ovr", 32'(ovr), 32'd0);
    step(1);
    check_eq("xc_valid_drop", 32'(dif.out_valid), 32'd0);
    en = 1'b0;
    step(5);
    check_eq("t4_drained", 32'(sb_q.size()), 32'd0);

    // Abort mid-window, then re-raise with a different pattern for a fresh count.
    mode = 1;
    en = 1'b1;
    step(104);
    en = 1'b0;
    step(2);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_valid", 32'(dif.out_valid), 32'd0);
    mode = 2;
    sb_q.push_back(8'd128);
    en = 1'b1;
    wait_valid(lat);
    check_eq("latency_rerun", 32'(lat), 32'd261);
    step(3);
    en = 1'b0;
    step(3);
    check_eq("t5_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-ACCUM with a pending result and overrun set.
    mode = 1;
    dif.out_ready = 1'b0;
    en = 1'b1;
    step(517);
    check_eq("pre_rst_ovr", 32'(ovr), 32'd1);
    step(50);
    rst = 1'b1;
    step(1);
    check_eq("mid_rst_valid", 32'(dif.out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(dif.out_data), 32'd0);
    check_eq("mid_rst_ovr", 32'(ovr), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    step(1);
    check_eq("rst_en_idle", 32'(busy), 32'd0);
    rst = 1'b0;
    en = 1'b0;
    step(3);
    check_eq("final_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
